// File: rtl/count_event_monitor_if.sv
// -----------------------------------------------------------------------------
// count_event_monitor_if
// Bus bundle between a count/threshold source and the count_event_monitor.
//   master : drives count, threshold, arm, disarm, irq_ack and clr_cnt, and
//            observes the monitor outputs.
//   slave  : the monitor itself. It samples the controls and drives irq,
//            state, wrap_pulse, thresh_pulse, wrap_cnt and overrun.
// The clock and reset are kept outside the bundle as plain module ports.
// -----------------------------------------------------------------------------
interface count_event_monitor_if #(
    parameter int WIDTH  = 8,
    parameter int WCNT_W = 8
);
    // Monitored value and its control inputs
    logic [WIDTH-1:0]  count;
    logic [WIDTH-1:0]  threshold;
    logic              arm;
    logic              disarm;
    logic              irq_ack;
    logic              clr_cnt;

    // Monitor results
    logic              irq;
    logic [1:0]        state;
    logic              wrap_pulse;
    logic              thresh_pulse;
    logic [WCNT_W-1:0] wrap_cnt;
    logic              overrun;

    modport master (
        output count, threshold, arm, disarm, irq_ack, clr_cnt,
        input  irq, state, wrap_pulse, thresh_pulse, wrap_cnt, overrun
    );

    modport slave (
        input  count, threshold, arm, disarm, irq_ack, clr_cnt,
        output irq, state, wrap_pulse, thresh_pulse, wrap_cnt, overrun
    );
endinterface

// File: rtl/count_event_monitor.sv
// -----------------------------------------------------------------------------
// count_event_monitor
// Watches the live value of an upstream down counter. It flags two events:
//   wrap      : the value moves from 0 to all-ones between two samples
//   threshold : the value arrives at the threshold (it was not there before)
// For each event it gives a one-cycle registered pulse. A saturating counter
// counts the wraps. A small FSM (IDLE / ARMED / PENDING) turns the first event
// after arming into a level interrupt, and the overrun flag is sticky: it
// records further events that come while that interrupt is pending.
//
// Ports
//   clk    : rising-edge clock for all state
//   rst_n  : asynchronous, active-low reset
//   bus    : count_event_monitor_if.slave
//            in : count, threshold, arm, disarm, irq_ack, clr_cnt
//            out: irq, state, wrap_pulse, thresh_pulse, wrap_cnt, overrun
// -----------------------------------------------------------------------------
module count_event_monitor #(
    parameter int WIDTH  = 8,
    parameter int WCNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    count_event_monitor_if.slave   bus
);

    // FSM encoding. The output state field uses this encoding directly.
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ARMED   = 2'b01;
    localparam logic [1:0] ST_PENDING = 2'b10;
    localparam logic [1:0] ST_UNUSED  = 2'b11;

    // Adds one to the wrap count, but holds the value once it reaches
    // all-ones. The count never rolls back over to zero.
    function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
        logic [WCNT_W-1:0] r;
        if (v == {WCNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + WCNT_W'(1);
        end
        return r;
    endfunction

    // Sample history
    logic [WIDTH-1:0]  prev_count_q;
    logic              prev_vld_q;

    // Registered outputs and their next-state values
    logic [1:0]        state_q,        state_d;
    logic              irq_q,          irq_d;
    logic              overrun_q,      overrun_d;
    logic              wrap_pulse_q;
    logic              thresh_pulse_q;
    logic [WCNT_W-1:0] wrap_cnt_q,     wrap_cnt_d;

    // Combinational event flags
    logic              wrap_evt_s;
    logic              thr_evt_s;
    logic              any_evt_s;

    // Event detection. Nothing is flagged until one sample has been taken
    // since reset. Because of this, a counter that is reset to all-ones at
    // the same time as this block does not look like a 0 -> all-ones wrap.
    always_comb begin
        wrap_evt_s = 1'b0;
        thr_evt_s  = 1'b0;
        if (prev_vld_q) begin
            wrap_evt_s = (prev_count_q == {WIDTH{1'b0}}) &&
                         (bus.count == {WIDTH{1'b1}});
            // Only the arrival counts. A value held at the threshold raises
            // nothing more after its first sample.
            thr_evt_s  = (bus.count == bus.threshold) &&
                         (prev_count_q != bus.threshold);
        end else begin
            wrap_evt_s = 1'b0;
            thr_evt_s  = 1'b0;
        end
    end

    assign any_evt_s = wrap_evt_s | thr_evt_s;

    // FSM next state and overrun tracking. disarm wins over every other
    // request and over any event on the same edge.
    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        if (bus.disarm) begin
            state_d   = ST_IDLE;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.arm) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (any_evt_s) begin
                        state_d = ST_PENDING;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_PENDING: begin
                    if (bus.irq_ack && any_evt_s) begin
                        // The new event re-raises at once, so irq stays high
                        // and overrun keeps its value.
                        state_d   = ST_PENDING;
                        overrun_d = overrun_q;
                    end else if (bus.irq_ack) begin
                        state_d   = ST_ARMED;
                        overrun_d = 1'b0;
                    end else if (any_evt_s) begin
                        state_d   = ST_PENDING;
                        overrun_d = 1'b1;
                    end else begin
                        state_d   = ST_PENDING;
                    end
                end
                ST_UNUSED: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        // irq comes from the next state, so it rises on the same edge that
        // the FSM enters PENDING.
        irq_d = (state_d == ST_PENDING);
    end

    // Wrap counter next value. A clear on the same edge as a wrap wins.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (bus.clr_cnt) begin
            wrap_cnt_d = {WCNT_W{1'b0}};
        end else if (wrap_evt_s) begin
            wrap_cnt_d = sat_inc(wrap_cnt_q);
        end else begin
            wrap_cnt_d = wrap_cnt_q;
        end
    end

    // Sample history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_count_q <= {WIDTH{1'b0}};
            prev_vld_q   <= 1'b0;
        end else begin
            prev_count_q <= bus.count;
            prev_vld_q   <= 1'b1;
        end
    end

    // Event pulses. They do not depend on the FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_pulse_q   <= 1'b0;
            thresh_pulse_q <= 1'b0;
        end else begin
            wrap_pulse_q   <= wrap_evt_s;
            thresh_pulse_q <= thr_evt_s;
        end
    end

    // FSM, interrupt, overrun and wrap counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            irq_q      <= 1'b0;
            overrun_q  <= 1'b0;
            wrap_cnt_q <= {WCNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            irq_q      <= irq_d;
            overrun_q  <= overrun_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign bus.state        = state_q;
    assign bus.irq          = irq_q;
    assign bus.overrun      = overrun_q;
    assign bus.wrap_pulse   = wrap_pulse_q;
    assign bus.thresh_pulse = thresh_pulse_q;
    assign bus.wrap_cnt     = wrap_cnt_q;

endmodule

// File: tb/tb_count_event_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_event_monitor
// Table of {inputs, expected outputs} rows applied one per clock, plus
// hand-written sequences: reset while PENDING, and wrap-count saturation
// followed by a clear on the same edge as a wrap. Expected rows go into a
// scoreboard queue when they are driven, and each one is taken out and
// compared once the edge has been taken.
// -----------------------------------------------------------------------------
module tb_count_event_monitor;

    typedef struct {
        logic [7:0] cnt;
        logic [7:0] thr;
        logic       arm;
        logic       dis;
        logic       ack;
        logic       clr;
        logic       irq;
        logic [1:0] st;
        logic       wp;
        logic       tp;
        logic [7:0] wc;
        logic       ovr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    vec_t sb[$];
    vec_t tbl[32];

    count_event_monitor_if #(.WIDTH(8), .WCNT_W(8)) bus ();

    count_event_monitor #(.WIDTH(8), .WCNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int cnt, input int thr, input int arm,
                                input int dis, input int ack, input int clr,
                                input int irq, input int st, input int wp,
                                input int tp, input int wc, input int ovr);
        vec_t v;
        v.cnt = 8'(cnt); v.thr = 8'(thr); v.arm = 1'(arm); v.dis = 1'(dis);
        v.ack = 1'(ack); v.clr = 1'(clr); v.irq = 1'(irq); v.st = 2'(st);
        v.wp  = 1'(wp);  v.tp  = 1'(tp);  v.wc  = 8'(wc);  v.ovr = 1'(ovr);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one row, take one edge, then compare the oldest expected row.
    task automatic step(input vec_t v);
        vec_t e;
        bus.count     = v.cnt;
        bus.threshold = v.thr;
        bus.arm       = v.arm;
        bus.disarm    = v.dis;
        bus.irq_ack   = v.ack;
        bus.clr_cnt   = v.clr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("irq",          int'(bus.irq),          int'(e.irq));
        chk("state",        int'(bus.state),        int'(e.st));
        chk("wrap_pulse",   int'(bus.wrap_pulse),   int'(e.wp));
        chk("thresh_pulse", int'(bus.thresh_pulse), int'(e.tp));
        chk("wrap_cnt",     int'(bus.wrap_cnt),     int'(e.wc));
        chk("overrun",      int'(bus.overrun),      int'(e.ovr));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_irq"},          int'(bus.irq),          0);
        chk({tag, "_state"},        int'(bus.state),        0);
        chk({tag, "_wrap_pulse"},   int'(bus.wrap_pulse),   0);
        chk({tag, "_thresh_pulse"}, int'(bus.thresh_pulse), 0);
        chk({tag, "_wrap_cnt"},     int'(bus.wrap_cnt),     0);
        chk({tag, "_overrun"},      int'(bus.overrun),      0);
    endtask

    initial begin
        int exp_wc;
        n_cmp = 0;
        n_err = 0;

        //           cnt  thr  arm dis ack clr  irq st  wp tp wc ovr
        tbl[0]  = mk(255, 200, 1, 0, 0, 0,   0, 1,  0, 0, 0, 0); // no wrap on first edge
        tbl[1]  = mk(2,   200, 0, 0, 0, 0,   0, 1,  0, 0, 0, 0);
        tbl[2]  = mk(1,   200, 0, 0, 0, 0,   0, 1,  0, 0, 0, 0);
        tbl[3]  = mk(0,   200, 0, 0, 0, 0,   0, 1,  0, 0, 0, 0);
        tbl[4]  = mk(255, 200, 0, 0, 0, 0,   1, 2,  1, 0, 1, 0); // wrap -> PENDING
        tbl[5]  = mk(255, 200, 0, 0, 0, 0,   1, 2,  0, 0, 1, 0); // held -> no event
        tbl[6]  = mk(0,   200, 0, 0, 0, 0,   1, 2,  0, 0, 1, 0);
        tbl[7]  = mk(255, 200, 0, 0, 0, 0,   1, 2,  1, 0, 2, 1); // overrun
        tbl[8]  = mk(255, 200, 0, 0, 1, 0,   0, 1,  0, 0, 2, 0); // ack
        tbl[9]  = mk(102, 100, 0, 0, 0, 0,   0, 1,  0, 0, 2, 0);
        tbl[10] = mk(101, 100, 0, 0, 0, 0,   0, 1,  0, 0, 2, 0);
        tbl[11] = mk(100, 100, 0, 0, 0, 0,   1, 2,  0, 1, 2, 0); // threshold arrival
        tbl[12] = mk(100, 100, 0, 0, 0, 0,   1, 2,  0, 0, 2, 0); // hold -> no pulse
        tbl[13] = mk(100, 100, 0, 0, 0, 0,   1, 2,  0, 0, 2, 0);
        tbl[14] = mk(99,  100, 0, 0, 0, 0,   1, 2,  0, 0, 2, 0);
        tbl[15] = mk(100, 100, 0, 0, 1, 0,   1, 2,  0, 1, 2, 0); // ack + event
        tbl[16] = mk(100, 100, 0, 0, 1, 0,   0, 1,  0, 0, 2, 0);
        tbl[17] = mk(0,   100, 0, 0, 0, 0,   0, 1,  0, 0, 2, 0);
        tbl[18] = mk(255, 100, 0, 0, 0, 0,   1, 2,  1, 0, 3, 0);
        tbl[19] = mk(0,   100, 0, 0, 0, 0,   1, 2,  0, 0, 3, 0);
        tbl[20] = mk(255, 100, 0, 0, 0, 0,   1, 2,  1, 0, 4, 1);
        tbl[21] = mk(0,   100, 0, 0, 0, 0,   1, 2,  0, 0, 4, 1);
        tbl[22] = mk(255, 100, 0, 1, 0, 0,   0, 0,  1, 0, 5, 0); // disarm + event
        tbl[23] = mk(255, 100, 1, 1, 0, 0,   0, 0,  0, 0, 5, 0); // arm + disarm
        tbl[24] = mk(254, 100, 0, 0, 1, 0,   0, 0,  0, 0, 5, 0); // ack in IDLE
        tbl[25] = mk(100, 100, 0, 0, 0, 0,   0, 0,  0, 1, 5, 0); // event in IDLE
        tbl[26] = mk(100, 100, 1, 0, 0, 0,   0, 1,  0, 0, 5, 0);
        tbl[27] = mk(100, 100, 1, 0, 0, 0,   0, 1,  0, 0, 5, 0); // arm in ARMED
        tbl[28] = mk(100, 100, 0, 0, 0, 1,   0, 1,  0, 0, 0, 0); // clr
        tbl[29] = mk(0,   100, 0, 0, 0, 0,   0, 1,  0, 0, 0, 0);
        tbl[30] = mk(255, 100, 0, 0, 0, 1,   1, 2,  1, 0, 0, 0); // clr + wrap
        tbl[31] = mk(255, 100, 0, 1, 0, 0,   0, 0,  0, 0, 0, 0);

        // Reset with the upstream counter already at all-ones
        rst_n         = 1'b0;
        bus.count     = 8'd255;
        bus.threshold = 8'd200;
        bus.arm       = 1'b0;
        bus.disarm    = 1'b0;
        bus.irq_ack   = 1'b0;
        bus.clr_cnt   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            step(tbl[i]);
        end

        // Reset while PENDING: irq drops at once, and arm is needed again
        step(mk(255, 100, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0));
        step(mk(0,   100, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0));
        step(mk(255, 100, 0, 0, 0, 0,   1, 2, 1, 0, 1, 0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(255, 100, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        step(mk(0,   100, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        step(mk(255, 100, 0, 0, 0, 0,   0, 0, 1, 0, 1, 0));

        // 300 more wraps: the count saturates at 255
        exp_wc = 1;
        for (int w = 0; w < 300; w++) begin
            step(mk(0, 100, 0, 0, 0, 0,   0, 0, 0, 0, exp_wc, 0));
            exp_wc = (exp_wc < 255) ? exp_wc + 1 : 255;
            step(mk(255, 100, 0, 0, 0, 0,   0, 0, 1, 0, exp_wc, 0));
        end
        chk("wrap_cnt_saturated", int'(bus.wrap_cnt), 255);
        step(mk(0,   100, 0, 0, 0, 0,   0, 0, 0, 0, 255, 0));
        step(mk(255, 100, 0, 0, 0, 1,   0, 0, 1, 0, 0,   0));

        chk("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
